// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, serialiser states and the divisor clamp.
package mmio_uart_tx_pkg;

   // Register offsets from the window base
   localparam logic [31:0] OFF_TXDATA  = 32'h0000_0000;
   localparam logic [31:0] OFF_STATUS  = 32'h0000_0004;
   localparam logic [31:0] OFF_DIVISOR = 32'h0000_0008;

   // STATUS register bit positions
   localparam int unsigned ST_FULL     = 0;
   localparam int unsigned ST_EMPTY    = 1;
   localparam int unsigned ST_BUSY     = 2;
   localparam int unsigned ST_OVERFLOW = 3;
   localparam int unsigned ST_COUNT    = 8;

   // Bit of a STATUS write that clears the sticky overflow flag
   localparam int unsigned CLR_OVERFLOW_BIT = 3;

   // Baud divisor width and the smallest value that keeps the down-counter sane
   localparam int unsigned DIV_W   = 16;
   localparam logic [15:0] DIV_MIN = 16'd2;

   // Serialiser states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   // Divisor values below the minimum are stored as the minimum
   function automatic logic [15:0] clamp_div(input logic [15:0] value);
      return (value < DIV_MIN) ? DIV_MIN : value;
   endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read data. Pointers carry one
// extra wrap bit so full and empty are distinguishable without a separate count.
module mmio_uart_tx_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   // A push into a full FIFO is dropped even if a pop happens in the same cycle
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count = wr_ptr - rd_ptr;
   assign rdata = mem[rd_ptr[AW-1:0]];

   // Pointer update; both pointers wrap naturally through the extra bit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Storage array; contents need no reset since empty masks them
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr[AW-1:0]] <= wdata;
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter. Stores to TXDATA queue bytes in a FIFO,
// a serialiser FSM shifts them out LSB first, and STATUS/DIVISOR are readable
// combinationally so firmware can poll the transmitter.
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        hit,
   output logic        tx,
   output logic        tx_busy
);

   import mmio_uart_tx_pkg::*;

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [15:0] DIV_RESET = 16'(CLKS_PER_BIT);

   // Address decode
   logic [31:0] offset;
   logic        sel_txdata;
   logic        sel_status;
   logic        sel_divisor;
   logic        wr_txdata;
   logic        wr_status;
   logic        wr_divisor;

   // Control registers
   logic [15:0] divisor;
   logic        overflow;
   logic [31:0] status;

   // FIFO interface
   logic [7:0]    fifo_rdata;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [CW-1:0] count_next;
   logic          push_ok;
   logic          pop;

   // Serialiser state
   tx_state_t   state;
   logic [15:0] cnt;
   logic [15:0] div_lat;
   logic [7:0]  shreg;
   logic [2:0]  bit_idx;
   logic        line;
   logic        stop_done;
   logic        frame_slot;
   logic        next_idle;

   logic unused_wdata;
   assign unused_wdata = ^WriteData[31:16];

   assign offset      = DataAdr - BASE_ADDR;
   assign sel_txdata  = (offset == OFF_TXDATA);
   assign sel_status  = (offset == OFF_STATUS);
   assign sel_divisor = (offset == OFF_DIVISOR);
   assign hit         = sel_txdata | sel_status | sel_divisor;

   assign wr_txdata  = MemWrite & sel_txdata;
   assign wr_status  = MemWrite & sel_status;
   assign wr_divisor = MemWrite & sel_divisor;

   mmio_uart_tx_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (wr_txdata),
      .wdata (WriteData[7:0]),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // A new frame can begin from IDLE or in the last cycle of a stop bit
   assign stop_done  = (state == STOP) && (cnt == '0);
   assign frame_slot = (state == IDLE) | stop_done;
   assign pop        = frame_slot & ~fifo_empty;
   assign next_idle  = frame_slot & fifo_empty;

   // Occupancy after this edge, so tx_busy tracks the next-state view
   assign push_ok    = wr_txdata & ~fifo_full;
   assign count_next = fifo_count + {{(CW-1){1'b0}}, push_ok} - {{(CW-1){1'b0}}, pop};

   // Divisor and sticky overflow registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         divisor  <= DIV_RESET;
         overflow <= 1'b0;
      end else begin
         if (wr_divisor) begin
            divisor <= clamp_div(WriteData[15:0]);
         end
         if (wr_txdata && fifo_full) begin
            overflow <= 1'b1;
         end else if (wr_status && WriteData[CLR_OVERFLOW_BIT]) begin
            overflow <= 1'b0;
         end
      end
   end

   // STATUS word assembly
   always_comb begin
      status                 = '0;
      status[ST_FULL]        = fifo_full;
      status[ST_EMPTY]       = fifo_empty;
      status[ST_BUSY]        = tx_busy;
      status[ST_OVERFLOW]    = overflow;
      status[ST_COUNT +: CW] = fifo_count;
   end

   // Combinational register read; TXDATA and misses read as zero
   always_comb begin
      ReadData = '0;
      if (sel_status) begin
         ReadData = status;
      end else if (sel_divisor) begin
         ReadData = {16'h0000, divisor};
      end
   end

   // Line level implied by the current state; registered into tx one cycle later
   always_comb begin
      line = 1'b1;
      unique case (state)
         START:   line = 1'b0;
         DATA:    line = shreg[0];
         default: line = 1'b1;
      endcase
   end

   // Serialiser FSM: every segment lasts div_lat cycles via a down-counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         div_lat <= DIV_RESET;
         shreg   <= '0;
         bit_idx <= '0;
         tx      <= 1'b1;
         tx_busy <= 1'b0;
      end else begin
         tx      <= line;
         tx_busy <= ~next_idle | (count_next != '0);
         unique case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  state   <= START;
                  shreg   <= fifo_rdata;
                  div_lat <= divisor;
                  cnt     <= divisor - 16'd1;
               end
            end
            START: begin
               if (cnt == '0) begin
                  state   <= DATA;
                  cnt     <= div_lat - 16'd1;
                  bit_idx <= '0;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            DATA: begin
               if (cnt == '0) begin
                  cnt     <= div_lat - 16'd1;
                  shreg   <= {1'b0, shreg[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                  end
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            STOP: begin
               if (cnt == '0) begin
                  // Chain straight into the next frame when data is waiting
                  if (!fifo_empty) begin
                     state   <= START;
                     shreg   <= fifo_rdata;
                     div_lat <= divisor;
                     cnt     <= divisor - 16'd1;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx. A frame-level model predicts when each
// byte appears on the line, FIFO occupancy and busy; the recorded tx/busy traces
// and register reads are compared against it.
module tb_mmio_uart_tx;

   localparam logic [31:0] BASE  = 32'hFFFF_0000;
   localparam int          DEPTH = 8;
   localparam int          TMAX  = 16384;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemWrite;
   logic [31:0] DataAdr;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        hit;
   logic        tx;
   logic        tx_busy;

   mmio_uart_tx dut (
      .clk       (clk),
      .reset     (reset),
      .MemWrite  (MemWrite),
      .DataAdr   (DataAdr),
      .WriteData (WriteData),
      .ReadData  (ReadData),
      .hit       (hit),
      .tx        (tx),
      .tx_busy   (tx_busy)
   );

   always #5 clk = ~clk;

   // cyc = number of rising edges so far; traces hold values seen after edge cyc
   int   cyc = 0;
   logic tx_trace   [TMAX];
   logic busy_trace [TMAX];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (cyc < TMAX) begin
         tx_trace[cyc]   = tx;
         busy_trace[cyc] = tx_busy;
      end
   end

   int checks = 0;
   int errors = 0;

   // ---------------- reference model ----------------
   typedef struct {
      int         push;
      int         start;
      int         div;
      logic [7:0] data;
   } frame_t;

   frame_t     frames[$];
   int         last_end;
   int         model_div;
   logic       model_ovf;

   function automatic void model_reset();
      frames.delete();
      last_end  = 0;
      model_div = 16;
      model_ovf = 1'b0;
   endfunction

   // Byte stored at edge e. The FSM takes a byte one edge before its start bit.
   function automatic bit model_push(int e, logic [7:0] b);
      int     occ = 0;
      frame_t f;
      foreach (frames[i]) begin
         if (frames[i].push < e && frames[i].start - 1 >= e) occ++;
      end
      if (occ >= DEPTH) begin
         model_ovf = 1'b1;
         return 1'b0;
      end
      f.push   = e;
      f.start  = (last_end > e + 2) ? last_end : e + 2;
      f.div    = model_div;
      f.data   = b;
      frames.push_back(f);
      last_end = f.start + 10 * model_div;
      return 1'b1;
   endfunction

   function automatic logic model_line(int k);
      foreach (frames[i]) begin
         if (k >= frames[i].start && k < frames[i].start + 10 * frames[i].div) begin
            int slot = (k - frames[i].start) / frames[i].div;
            if (slot == 0) return 1'b0;
            if (slot == 9) return 1'b1;
            return frames[i].data[slot-1];
         end
      end
      return 1'b1;
   endfunction

   // Bytes still queued after edge k
   function automatic int model_occ(int k);
      int n = 0;
      foreach (frames[i]) begin
         if (frames[i].push <= k && frames[i].start - 1 > k) n++;
      end
      return n;
   endfunction

   function automatic logic model_busy(int k);
      foreach (frames[i]) begin
         if (frames[i].push <= k && k < frames[i].start - 1 + 10 * frames[i].div) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_status(int k);
      int n = model_occ(k);
      logic [31:0] s = '0;
      s[0]    = (n == DEPTH);
      s[1]    = (n == 0);
      s[2]    = model_busy(k);
      s[3]    = model_ovf;
      s[11:8] = 4'(n);
      return s;
   endfunction

   // ---------------- bus helpers (stimulus only) ----------------
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output int e);
      DataAdr   = a;
      WriteData = d;
      MemWrite  = 1'b1;
      @(posedge clk);
      #1;
      e         = cyc;
      MemWrite  = 1'b0;
      DataAdr   = '0;
      WriteData = '0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic h);
      DataAdr = a;
      #1;
      d       = ReadData;
      h       = hit;
      DataAdr = '0;
      @(posedge clk);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] b, output int e, output bit accepted);
      bus_write(BASE, {24'h0, b}, e);
      accepted = model_push(e, b);
   endtask

   task automatic write_div(input logic [15:0] v);
      int e;
      bus_write(BASE + 32'h8, {16'h0, v}, e);
      model_div = (v < 16'd2) ? 2 : int'(v);
   endtask

   task automatic wait_until(input int k);
      while (cyc < k) @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [31:0] d;
      logic        h;
      int          e;
      bit          acc;
      int          bad;
      int          k0;

      bus_read(BASE + 32'h4, d, h);
      checks++;
      if (d !== 32'h0000_0002 || h !== 1'b1) begin
         errors++;
         $display("FAIL reset_status got=%h hit=%b want=00000002 hit=1", d, h);
      end
      bus_read(BASE + 32'h8, d, h);
      checks++;
      if (d !== 32'd16) begin
         errors++;
         $display("FAIL reset_divisor got=%0d want=16", d);
      end
      checks++;
      if (tx !== 1'b1 || tx_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_line tx=%b busy=%b want tx=1 busy=0", tx, tx_busy);
      end

      // Start a frame, then reset in the middle of a data bit
      push_byte(8'($urandom_range(0, 255)) & 8'hFE, e, acc);
      bus_write(BASE, 32'h0000_00C3, k0);
      void'(model_push(k0, 8'hC3));
      wait_until(e + 2 + 16 + 5);
      checks++;
      if (tx_trace[e + 3] !== model_line(e + 3)) begin
         errors++;
         $display("FAIL pre_reset_start got=%b want=%b", tx_trace[e + 3], model_line(e + 3));
      end
      #3;
      reset = 1'b1;
      #1;
      checks++;
      if (tx !== 1'b1 || tx_busy !== 1'b0) begin
         errors++;
         $display("FAIL async_reset tx=%b busy=%b want tx=1 busy=0", tx, tx_busy);
      end
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      k0 = cyc;
      bus_read(BASE + 32'h4, d, h);
      checks++;
      if (d !== 32'h0000_0002) begin
         errors++;
         $display("FAIL post_reset_status got=%h want=00000002", d);
      end
      bus_read(BASE + 32'h8, d, h);
      checks++;
      if (d !== 32'd16) begin
         errors++;
         $display("FAIL post_reset_divisor got=%0d want=16", d);
      end
      // The abandoned frame and the queued byte must never appear
      wait_until(k0 + 200);
      bad = -1;
      for (int k = k0; k < k0 + 200; k++) begin
         if (bad < 0 && tx_trace[k] !== 1'b1) bad = k;
      end
      checks++;
      if (bad >= 0) begin
         errors++;
         $display("FAIL post_reset_idle cycle=%0d got=%b want=1", bad, tx_trace[bad]);
      end
   endtask

   task automatic test_single(input logic [7:0] b);
      int e;
      bit acc;
      int bad;
      int hi;

      push_byte(b, e, acc);
      hi = last_end + 3;
      wait_until(hi + 1);
      bad = -1;
      for (int k = e + 1; k <= hi; k++) begin
         if (bad < 0 && tx_trace[k] !== model_line(k)) bad = k;
      end
      checks++;
      if (bad >= 0) begin
         errors++;
         $display("FAIL single_%h cycle=%0d got=%b want=%b", b, bad - e, tx_trace[bad],
                  model_line(bad));
      end
      checks++;
      if (busy_trace[e] !== 1'b1 || busy_trace[e - 1] !== 1'b0) begin
         errors++;
         $display("FAIL single_busy_rise before=%b at=%b want 0 then 1", busy_trace[e - 1],
                  busy_trace[e]);
      end
      checks++;
      if (busy_trace[e + 160] !== model_busy(e + 160) ||
          busy_trace[e + 163] !== model_busy(e + 163)) begin
         errors++;
         $display("FAIL single_busy_fall at160=%b at163=%b want %b %b", busy_trace[e + 160],
                  busy_trace[e + 163], model_busy(e + 160), model_busy(e + 163));
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] bytes[5];
      int         e0;
      int         e;
      bit         acc;
      int         bad;
      int         hi;

      bytes[0] = 8'hA1;
      bytes[1] = 8'h0F;
      bytes[2] = 8'hFF;
      bytes[3] = 8'($urandom_range(0, 255));
      bytes[4] = 8'($urandom_range(0, 255));
      e0 = 0;
      for (int i = 0; i < 5; i++) begin
         push_byte(bytes[i], e, acc);
         if (i == 0) e0 = e;
      end
      hi = last_end + 3;
      wait_until(hi + 1);
      bad = -1;
      for (int k = e0 + 1; k <= hi; k++) begin
         if (bad < 0 && tx_trace[k] !== model_line(k)) bad = k;
      end
      checks++;
      if (bad >= 0) begin
         errors++;
         $display("FAIL back_to_back cycle=%0d got=%b want=%b", bad - e0, tx_trace[bad],
                  model_line(bad));
      end
      // No idle gap: busy never drops between the first push and the last stop
      bad = -1;
      for (int k = e0; k < last_end - 2; k++) begin
         if (bad < 0 && busy_trace[k] !== 1'b1) bad = k;
      end
      checks++;
      if (bad >= 0) begin
         errors++;
         $display("FAIL back_to_back_busy cycle=%0d got=%b want=1", bad - e0, busy_trace[bad]);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] d;
      logic        h;
      int          e0;
      int          e;
      bit          acc;
      int          bad;
      int          hi;
      logic [31:0] exp;

      write_div(16'd4);
      push_byte(8'($urandom_range(0, 255)), e0, acc);
      wait_until(e0 + 5);
      for (int i = 0; i < DEPTH; i++) begin
         push_byte(8'($urandom_range(0, 255)), e, acc);
      end
      push_byte(8'h3C, e, acc);
      checks++;
      if (acc !== 1'b0) begin
         errors++;
         $display("FAIL overflow_model_setup accepted=%b want=0", acc);
      end
      exp = model_status(cyc);
      bus_read(BASE + 32'h4, d, h);
      checks++;
      if (d !== exp || d[0] !== 1'b1 || d[3] !== 1'b1) begin
         errors++;
         $display("FAIL overflow_status got=%h want=%h", d, exp);
      end
      // A STATUS write without bit 3 leaves the flag alone
      bus_write(BASE + 32'h4, 32'h0000_0007, e);
      exp = model_status(cyc);
      bus_read(BASE + 32'h4, d, h);
      checks++;
      if (d[3] !== exp[3]) begin
         errors++;
         $display("FAIL overflow_keep got=%b want=%b", d[3], exp[3]);
      end
      bus_write(BASE + 32'h4, 32'h0000_0008, e);
      model_ovf = 1'b0;
      exp = model_status(cyc);
      bus_read(BASE + 32'h4, d, h);
      checks++;
      if (d !== exp) begin
         errors++;
         $display("FAIL overflow_clear got=%h want=%h", d, exp);
      end
      hi = last_end + 40;
      wait_until(hi + 1);
      bad = -1;
      for (int k = e0 + 1; k <= hi; k++) begin
         if (bad < 0 && tx_trace[k] !== model_line(k)) bad = k;
      end
      checks++;
      if (bad >= 0) begin
         errors++;
         $display("FAIL overflow_wave cycle=%0d got=%b want=%b", bad - e0, tx_trace[bad],
                  model_line(bad));
      end
      write_div(16'd16);
   endtask

   task automatic test_divisor();
      logic [31:0] d;
      logic        h;
      logic [15:0] wv[4];
      int          e0;
      int          e;
      bit          acc;
      int          bad;
      int          hi;

      push_byte(8'($urandom_range(0, 255)), e0, acc);
      wait_until(e0 + 20);
      write_div(16'd4);
      push_byte(8'($urandom_range(0, 255)), e, acc);
      bus_read(BASE + 32'h8, d, h);
      checks++;
      if (d !== 32'd4) begin
         errors++;
         $display("FAIL divisor_readback got=%0d want=4", d);
      end
      hi = last_end + 3;
      wait_until(hi + 1);
      bad = -1;
      for (int k = e0 + 1; k <= hi; k++) begin
         if (bad < 0 && tx_trace[k] !== model_line(k)) bad = k;
      end
      checks++;
      if (bad >= 0) begin
         errors++;
         $display("FAIL divisor_midframe cycle=%0d got=%b want=%b", bad - e0, tx_trace[bad],
                  model_line(bad));
      end
      wv[0] = 16'd0;
      wv[1] = 16'd1;
      wv[2] = 16'd3;
      wv[3] = 16'($urandom_range(2, 65535));
      for (int i = 0; i < 4; i++) begin
         write_div(wv[i]);
         bus_read(BASE + 32'h8, d, h);
         checks++;
         if (d !== 32'(model_div)) begin
            errors++;
            $display("FAIL divisor_clamp wrote=%0d got=%0d want=%0d", wv[i], d, model_div);
         end
      end
      write_div(16'd16);
   endtask

   task automatic test_decode();
      logic [31:0] d;
      logic        h;
      int          e0;
      int          e;
      int          bad;

      bus_write(BASE + 32'hC, 32'h0000_0077, e0);
      bus_write(32'h0000_0064, 32'h0000_0099, e);
      bus_write(BASE - 32'h4, 32'h0000_0011, e);
      bus_read(BASE + 32'hC, d, h);
      checks++;
      if (h !== 1'b0 || d !== 32'h0) begin
         errors++;
         $display("FAIL decode_base_c hit=%b data=%h want hit=0 data=0", h, d);
      end
      bus_read(32'h0000_0064, d, h);
      checks++;
      if (h !== 1'b0 || d !== 32'h0) begin
         errors++;
         $display("FAIL decode_0x64 hit=%b data=%h want hit=0 data=0", h, d);
      end
      bus_read(BASE, d, h);
      checks++;
      if (h !== 1'b1 || d !== 32'h0) begin
         errors++;
         $display("FAIL decode_txdata hit=%b data=%h want hit=1 data=0", h, d);
      end
      bus_read(BASE + 32'h4, d, h);
      checks++;
      if (d !== model_status(cyc)) begin
         errors++;
         $display("FAIL decode_status got=%h want=%h", d, model_status(cyc));
      end
      wait_until(e0 + 60);
      bad = -1;
      for (int k = e0; k < e0 + 60; k++) begin
         if (bad < 0 && tx_trace[k] !== 1'b1) bad = k;
      end
      checks++;
      if (bad >= 0) begin
         errors++;
         $display("FAIL decode_no_tx cycle=%0d got=%b want=1", bad - e0, tx_trace[bad]);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      MemWrite  = 1'b0;
      DataAdr   = '0;
      WriteData = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;

      test_reset();
      test_single(8'h55);
      test_single(8'($urandom_range(0, 255)));
      test_back_to_back();
      test_overflow();
      test_divisor();
      test_decode();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
